demux_1a2_32bit_reg: RTL and testbench

- Registered 1-to-2 demultiplexer with valid/ready handshake; the inverse of the 2-to-1 32-bit select mux.
- Steers one 32-bit producer stream, e.g. a write-back or load-data result, to one of two consumers chosen by SEL.
- Each output has its own one-entry holding register, so one stalled consumer does not corrupt data sent to the other.
- Sits between the datapath result and two downstream stages.

---
 rtl/demux_1a2_32bit_reg.sv | 120 ++++++++++++
 tb/tb_demux_1a2_32bit_reg.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/demux_1a2_32bit_reg.sv
// Registered 1-to-2 demultiplexer with valid/ready handshake and a one-entry holding register per output.
// Optional per-output accepted-word counters are built when DEMUX_CNT_EN is defined.
//
// state | meaning
// EMPTY | holding register k has no word, OUTk_VALID=0
// FULL  | holding register k holds a word, OUTk_VALID=1
module demux_1a2_32bit_reg #(
   parameter int WIDTH = 32
`ifdef DEMUX_CNT_EN
   ,
   parameter int CNT_W = 16
`endif
) (
   input  logic             clk_i,
   input  logic             rst_n_i,
   input  logic             in_valid_i,
   output logic             in_ready_o,
   input  logic [WIDTH-1:0] in_data_i,
   input  logic             sel_i,
   output logic             out0_valid_o,
   input  logic             out0_ready_i,
   output logic [WIDTH-1:0] out0_data_o,
   output logic             out1_valid_o,
   input  logic             out1_ready_i,
   output logic [WIDTH-1:0] out1_data_o
`ifdef DEMUX_CNT_EN
   ,
   output logic [CNT_W-1:0] cnt0_o,
   output logic [CNT_W-1:0] cnt1_o
`endif
);

   typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} hold_state_t;

   hold_state_t      state0_q, state0_d;
   hold_state_t      state1_q, state1_d;
   logic [WIDTH-1:0] data0_q, data0_d;
   logic [WIDTH-1:0] data1_q, data1_d;
   logic             in_xfer;
   logic             wr0, wr1;

   // Ready is a function of the selected register only, never of in_valid_i.
   always_comb begin
      in_ready_o = 1'b0;
      if (sel_i) in_ready_o = (state1_q == EMPTY) | out1_ready_i;
      else       in_ready_o = (state0_q == EMPTY) | out0_ready_i;
   end

   assign in_xfer = in_valid_i & in_ready_o;
   assign wr0     = in_xfer & ~sel_i;
   assign wr1     = in_xfer & sel_i;

   always_comb begin
      state0_d = state0_q;
      data0_d  = data0_q;
      if (wr0) begin
         state0_d = FULL;
         data0_d  = in_data_i;
      end else if ((state0_q == FULL) && out0_ready_i) begin
         state0_d = EMPTY;
      end
   end

   always_comb begin
      state1_d = state1_q;
      data1_d  = data1_q;
      if (wr1) begin
         state1_d = FULL;
         data1_d  = in_data_i;
      end else if ((state1_q == FULL) && out1_ready_i) begin
         state1_d = EMPTY;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         state0_q <= EMPTY;
         state1_q <= EMPTY;
         data0_q  <= '0;
         data1_q  <= '0;
      end else begin
         state0_q <= state0_d;
         state1_q <= state1_d;
         data0_q  <= data0_d;
         data1_q  <= data1_d;
      end
   end

   assign out0_valid_o = (state0_q == FULL);
   assign out1_valid_o = (state1_q == FULL);
   assign out0_data_o  = data0_q;
   assign out1_data_o  = data1_q;

`ifdef DEMUX_CNT_EN
   logic [CNT_W-1:0] cnt0_q, cnt0_d;
   logic [CNT_W-1:0] cnt1_q, cnt1_d;

   // Counters wrap naturally at 2^CNT_W.
   always_comb begin
      cnt0_d = cnt0_q;
      cnt1_d = cnt1_q;
      if (wr0) cnt0_d = cnt0_q + 1'b1;
      if (wr1) cnt1_d = cnt1_q + 1'b1;
   end

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         cnt0_q <= '0;
         cnt1_q <= '0;
      end else begin
         cnt0_q <= cnt0_d;
         cnt1_q <= cnt1_d;
      end
   end

   assign cnt0_o = cnt0_q;
   assign cnt1_o = cnt1_q;
`endif

endmodule

// File: tb/tb_demux_1a2_32bit_reg.sv
// Self-checking bench for demux_1a2_32bit_reg: directed scenarios plus random traffic against a queue model.
// Counter checks are compiled in when DEMUX_CNT_EN is defined (counters built with CNT_W=4).
module tb_demux_1a2_32bit_reg;

`ifdef DEMUX_CNT_EN
   localparam int TB_CNT_W = 4;
`endif

   logic        clk_i = 1'b0;
   logic        rst_n_i = 1'b0;
   logic        in_valid_i = 1'b0;
   logic        in_ready_o;
   logic [31:0] in_data_i = '0;
   logic        sel_i = 1'b0;
   logic        out0_valid_o, out1_valid_o;
   logic        out0_ready_i = 1'b0, out1_ready_i = 1'b0;
   logic [31:0] out0_data_o, out1_data_o;
`ifdef DEMUX_CNT_EN
   logic [TB_CNT_W-1:0] cnt0_o, cnt1_o;
`endif

   demux_1a2_32bit_reg #(
      .WIDTH(32)
`ifdef DEMUX_CNT_EN
      ,
      .CNT_W(TB_CNT_W)
`endif
   ) dut (
      .clk_i(clk_i), .rst_n_i(rst_n_i),
      .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_data_i(in_data_i), .sel_i(sel_i),
      .out0_valid_o(out0_valid_o), .out0_ready_i(out0_ready_i), .out0_data_o(out0_data_o),
      .out1_valid_o(out1_valid_o), .out1_ready_i(out1_ready_i), .out1_data_o(out1_data_o)
`ifdef DEMUX_CNT_EN
      ,
      .cnt0_o(cnt0_o), .cnt1_o(cnt1_o)
`endif
   );

   always #5 clk_i = ~clk_i;

   int checks = 0;
   int errors = 0;

   // Reference model: one word slot per output, last data written, accepted-word totals.
   logic [31:0] q0[$];
   logic [31:0] q1[$];
   logic [31:0] last0 = '0, last1 = '0;
   int unsigned mc0 = 0, mc1 = 0;
   logic        obs_ready;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Applies one cycle of inputs, checks the visible state against the model, then advances both.
   task automatic step(input logic rst_n, input logic iv, input logic isel, input logic [31:0] id,
                       input logic r0, input logic r1);
      logic exp_ready, in_x, o0x, o1x;
      rst_n_i = rst_n; in_valid_i = iv; sel_i = isel; in_data_i = id;
      out0_ready_i = r0; out1_ready_i = r1;
      #1;
      exp_ready = isel ? (q1.size() == 0 || r1) : (q0.size() == 0 || r0);
      obs_ready = in_ready_o;
      chk("in_ready", {31'b0, in_ready_o}, {31'b0, exp_ready});
      chk("out0_valid", {31'b0, out0_valid_o}, {31'b0, q0.size() != 0});
      chk("out1_valid", {31'b0, out1_valid_o}, {31'b0, q1.size() != 0});
      chk("out0_data", out0_data_o, last0);
      chk("out1_data", out1_data_o, last1);
`ifdef DEMUX_CNT_EN
      chk("cnt0", {{(32-TB_CNT_W){1'b0}}, cnt0_o}, mc0 % (32'd1 << TB_CNT_W));
      chk("cnt1", {{(32-TB_CNT_W){1'b0}}, cnt1_o}, mc1 % (32'd1 << TB_CNT_W));
`endif
      in_x = iv && exp_ready;
      o0x  = q0.size() != 0 && r0;
      o1x  = q1.size() != 0 && r1;
      @(posedge clk_i);
      if (!rst_n) begin
         q0.delete(); q1.delete();
         last0 = '0; last1 = '0; mc0 = 0; mc1 = 0;
      end else begin
         if (o0x) void'(q0.pop_front());
         if (o1x) void'(q1.pop_front());
         if (in_x && !isel) begin q0.push_back(id); last0 = id; mc0++; end
         if (in_x && isel)  begin q1.push_back(id); last1 = id; mc1++; end
      end
      @(negedge clk_i);
   endtask

   initial begin
      logic        hold;
      logic        rs, rv;
      logic [31:0] rd;
      @(negedge clk_i);
      step(0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0);

      // Reset mid-operation
      step(1, 1, 0, 32'hDEADBEEF, 0, 0);
      step(1, 0, 0, 0, 0, 0);
      chk("pre_rst_d0", out0_data_o, 32'hDEADBEEF);
      step(0, 0, 0, 0, 0, 0);
      sel_i = 0; out0_ready_i = 0; rst_n_i = 1; #1;
      chk("rst_v0", {31'b0, out0_valid_o}, 32'd0);
      chk("rst_d0", out0_data_o, 32'd0);
      chk("rst_ready", {31'b0, in_ready_o}, 32'd1);
`ifdef DEMUX_CNT_EN
      chk("rst_cnt0", {{(32-TB_CNT_W){1'b0}}, cnt0_o}, 32'd0);
`endif

      // Basic steer
      step(1, 1, 1, 32'h12345678, 0, 1);
      chk("steer_v1", {31'b0, out1_valid_o}, 32'd1);
      chk("steer_d1", out1_data_o, 32'h12345678);
      chk("steer_v0", {31'b0, out0_valid_o}, 32'd0);
`ifdef DEMUX_CNT_EN
      chk("steer_cnt1", {{(32-TB_CNT_W){1'b0}}, cnt1_o}, 32'd1);
      chk("steer_cnt0", {{(32-TB_CNT_W){1'b0}}, cnt0_o}, 32'd0);
`endif
      step(1, 0, 0, 0, 1, 1);

      // Back-pressure
      step(1, 1, 0, 32'hA, 0, 0);
      chk("bp_a_acc", {31'b0, obs_ready}, 32'd1);
      step(1, 1, 0, 32'hB, 0, 0);
      chk("bp_b_stall", {31'b0, obs_ready}, 32'd0);
      chk("bp_a_held", out0_data_o, 32'hA);
      step(1, 1, 0, 32'hB, 1, 0);
      chk("bp_b_acc", {31'b0, obs_ready}, 32'd1);
      chk("bp_b_out", out0_data_o, 32'hB);
      chk("bp_b_v", {31'b0, out0_valid_o}, 32'd1);
      step(1, 0, 0, 0, 1, 1);

      // Independence
      step(1, 1, 0, 32'h1, 0, 0);
      step(1, 1, 1, 32'h2, 0, 1);
      chk("ind_ready", {31'b0, obs_ready}, 32'd1);
      chk("ind_d1", out1_data_o, 32'h2);
      chk("ind_d0", out0_data_o, 32'h1);
      step(1, 0, 0, 0, 1, 1);

      // Throughput
      for (int i = 0; i < 8; i++) begin
         step(1, 1, i[0], i, 1, 1);
         chk("thr_ready", {31'b0, obs_ready}, 32'd1);
         chk("thr_data", i[0] ? out1_data_o : out0_data_o, i);
      end
      step(1, 0, 0, 0, 1, 1);

      // Random traffic; producer holds sel/data while stalled
      hold = 0; rs = 0; rd = '0; rv = 0;
      for (int n = 0; n < 400; n++) begin
         if (!hold) begin
            rv = $urandom_range(0, 3) != 0;
            rs = $urandom_range(0, 1) == 1;
            rd = $urandom;
         end
         step(($urandom_range(0, 60) != 0) ? 1'b1 : 1'b0, rv, rs, rd,
              $urandom_range(0, 2) != 0, $urandom_range(0, 2) != 0);
         hold = rv && !obs_ready && rst_n_i;
      end

`ifdef DEMUX_CNT_EN
      // Counter wrap with CNT_W=4
      step(0, 0, 0, 0, 0, 0);
      for (int i = 1; i <= 17; i++) begin
         step(1, 1, 0, 32'h100 + i, 1, 0);
         if (i == 15) chk("wrap_15", {28'b0, cnt0_o}, 32'd15);
         if (i == 16) chk("wrap_16", {28'b0, cnt0_o}, 32'd0);
         if (i == 17) chk("wrap_17", {28'b0, cnt0_o}, 32'd1);
      end
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
